// File: rtl/step_pulse_pkg.sv
// Shared definitions for the step pulse generator: run-state encoding,
// control-register bit positions and default timing parameters.
package step_pulse_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVE   = 2'd1,
        MOVE_N = 2'd2,
        AUTO   = 2'd3
    } regime_t;

    localparam int CR_START   = 0;
    localparam int CR_START_N = 1;
    localparam int CR_STOP    = 2;
    localparam int CR_AUTO    = 3;
    localparam int CR_DIR     = 4;
    localparam int CR_INVERT  = 5;

    localparam int DEF_MIN_PERIOD = 4;
    localparam int DEF_DUTY_SHIFT = 2;

endpackage

// File: rtl/step_period_timer.sv
// Period counter for the step generator: clamps the period, produces the duty
// window, the wrap flag and the pause/emit qualifiers for the first cycle of a period.
module step_period_timer
    import step_pulse_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int NUM_PERIOD = 2000,
    parameter int DUTY_SHIFT = DEF_DUTY_SHIFT,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            run,
    input  logic            en,
    input  logic [SIZE-1:0] period,
    output logic            step,
    output logic            wrap,
    output logic            hold,
    output logic            emit
);
    localparam logic [SIZE-1:0] MIN_P = SIZE'(MIN_PERIOD);
    localparam logic [SIZE-1:0] ONE   = SIZE'(1);

    logic [SIZE-1:0] cnt;
    logic [SIZE-1:0] active;
    logic [SIZE-1:0] p_clamped;
    logic [SIZE-1:0] p_last;
    logic [SIZE-1:0] high;

    assign p_clamped = (active < MIN_P) ? MIN_P : active;
    assign p_last    = p_clamped - ONE;

    always_comb begin
        high = p_clamped >> DUTY_SHIFT;
        if (high == '0) begin
            high = ONE;
        end
    end

    // A disabled driver freezes the timer only at the start of a period,
    // so a pulse already in progress always runs to completion.
    assign hold = run & (cnt == '0) & ~en;
    assign wrap = run & (cnt == p_last);
    assign emit = run & ~hold & (cnt == '0);
    assign step = run & ~hold & (cnt < high);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt    <= '0;
            active <= SIZE'(NUM_PERIOD);
        end else if (!run) begin
            cnt    <= '0;
            active <= period;
        end else if (hold) begin
            cnt <= '0;
        end else if (wrap) begin
            cnt    <= '0;
            active <= period;
        end else begin
            cnt <= cnt + ONE;
        end
    end

endmodule

// File: rtl/step_pulse_gen.sv
// Step/direction pulse generator: command decode, run-state FSM, MOVE_N pulse
// accounting and registered driver outputs around a shared period timer.
module step_pulse_gen
    import step_pulse_pkg::*;
#(
    parameter int SIZE       = 16,
    parameter int NUM_PERIOD = 2000,
    parameter int DUTY_SHIFT = DEF_DUTY_SHIFT,
    parameter int MIN_PERIOD = DEF_MIN_PERIOD
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [7:0]      cr,
    input  logic            d_v,
    input  logic [SIZE-1:0] n,
    input  logic [SIZE-1:0] n_pulses,
    input  logic            drv_en_SM,
    output logic            drv_pulse,
    output logic            drv_dir,
    output logic            busy,
    output logic            done,
    output logic [SIZE-1:0] pulses_left,
    output logic [1:0]      regime
);
    localparam logic [SIZE-1:0] FIXED_PERIOD = SIZE'(NUM_PERIOD);
    localparam logic [SIZE-1:0] ONE          = SIZE'(1);

    logic [1:0]      rst_pipe;
    logic            rst_sync;
    logic [4:0]      cr_q;
    logic [1:0]      cr_prev;
    logic            armed;
    logic            start_rise;
    logic            start_n_rise;
    logic            stop_lvl;
    logic            auto_lvl;
    logic            unused_cr;
    logic [SIZE-1:0] shadow;
    logic [SIZE-1:0] period_src;
    regime_t         state;
    logic            run;
    logic            step;
    logic            wrap;
    logic            hold;
    logic            emit;
    logic            finish;

    // Assert asynchronously, release two clocks after rst rises.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rst_pipe <= 2'b00;
        end else begin
            rst_pipe <= {rst_pipe[0], 1'b1};
        end
    end
    assign rst_sync = rst_pipe[1];

    // The first clock after reset seeds the edge history from the live
    // inputs, so a start level held through reset is not seen as an edge.
    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            cr_q    <= '0;
            cr_prev <= '0;
            armed   <= 1'b0;
        end else begin
            cr_q    <= cr[4:0];
            cr_prev <= armed ? cr_q[1:0] : cr[1:0];
            armed   <= 1'b1;
        end
    end

    assign start_rise   = cr_q[CR_START] & ~cr_prev[CR_START];
    assign start_n_rise = cr_q[CR_START_N] & ~cr_prev[CR_START_N];
    assign stop_lvl     = cr_q[CR_STOP];
    assign auto_lvl     = cr_q[CR_AUTO];
    assign unused_cr    = ^cr[7:6];

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            shadow <= FIXED_PERIOD;
        end else if (d_v) begin
            shadow <= n;
        end
    end

    assign run        = (state != IDLE);
    assign period_src = ((state == AUTO) || ((state == IDLE) && auto_lvl)) ? shadow : FIXED_PERIOD;

    step_period_timer #(
        .SIZE       (SIZE),
        .NUM_PERIOD (NUM_PERIOD),
        .DUTY_SHIFT (DUTY_SHIFT),
        .MIN_PERIOD (MIN_PERIOD)
    ) u_timer (
        .clk    (clk),
        .rst    (rst_sync),
        .run    (run),
        .en     (drv_en_SM),
        .period (period_src),
        .step   (step),
        .wrap   (wrap),
        .hold   (hold),
        .emit   (emit)
    );

    // End of motion is taken only at a period boundary, except that a stop
    // during a driver pause ends the move at once.
    always_comb begin
        finish = 1'b0;
        case (state)
            MOVE:    finish = stop_lvl & (hold | wrap);
            MOVE_N:  finish = (stop_lvl & (hold | wrap)) | (wrap & (pulses_left == '0));
            AUTO:    finish = (stop_lvl & (hold | wrap)) | (wrap & ~auto_lvl);
            default: finish = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_sync) begin
        if (!rst_sync) begin
            state       <= IDLE;
            busy        <= 1'b0;
            done        <= 1'b0;
            drv_pulse   <= 1'b0;
            drv_dir     <= 1'b0;
            pulses_left <= '0;
        end else begin
            done      <= 1'b0;
            drv_pulse <= step ^ cr[CR_INVERT];
            if (state == IDLE) begin
                if (!stop_lvl) begin
                    if (auto_lvl) begin
                        state       <= AUTO;
                        busy        <= 1'b1;
                        drv_dir     <= cr_q[CR_DIR];
                        pulses_left <= '0;
                    end else if (start_rise) begin
                        state       <= MOVE;
                        busy        <= 1'b1;
                        drv_dir     <= cr_q[CR_DIR];
                        pulses_left <= '0;
                    end else if (start_n_rise) begin
                        if (n_pulses == '0) begin
                            done <= 1'b1;
                        end else begin
                            state       <= MOVE_N;
                            busy        <= 1'b1;
                            drv_dir     <= cr_q[CR_DIR];
                            pulses_left <= n_pulses;
                        end
                    end
                end
            end else if (finish) begin
                state <= IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
            end else if ((state == MOVE_N) && emit && (pulses_left != '0)) begin
                pulses_left <= pulses_left - ONE;
            end
        end
    end

    assign regime = state;

endmodule

// File: doc/step_pulse_gen.md
STEP_PULSE_GEN -- requirements
Module: step_pulse_gen

Interface
REQ-001 Parameter SIZE, default 16: width of the period and pulse-count fields.
REQ-002 Parameter NUM_PERIOD, default 2000: fixed period in MOVE and MOVE_N (25 kHz at 50 MHz).
REQ-003 Parameter DUTY_SHIFT, default 2: high time = period >> DUTY_SHIFT.
REQ-004 Parameter MIN_PERIOD, default 4: floor applied to any period value.
REQ-005 Ports, in order:
- clk, input, 1: single 50 MHz clock.
- rst, input, 1: asynchronous, active-low reset.
- cr, input, 8: control register. [0] start, [1] start_N, [2] stop, [3] auto, [4] dir, [5] invert, [7:6] reserved.
- d_v, input, 1: ADC data-valid strobe, which loads n into the shadow period.
- n, input, SIZE: period for AUTO.
- n_pulses, input, SIZE: pulse count for MOVE_N.
- drv_en_SM, input, 1: motor enable (pause when low).
- drv_pulse, output, 1: step pulse.
- drv_dir, output, 1: latched direction.
- busy, output, 1: high when state is not IDLE.
- done, output, 1: one-cycle completion strobe.
- pulses_left, output, SIZE: remaining pulses in MOVE_N.
- regime, output, 2: current state.

Function
REQ-006 The FSM SHALL have four states: IDLE=0, MOVE=1, MOVE_N=2, AUTO=3.
REQ-007 cr[0] and cr[1] SHALL act on their rising edges (registered edge detect); cr[2] and cr[3] SHALL act as levels.
REQ-008 Transitions from IDLE SHALL use this priority:
- stop: stay in IDLE.
- auto: go to AUTO.
- start rise: go to MOVE.
- start_N rise: go to MOVE_N.
REQ-009 Start commands received outside IDLE SHALL be ignored.
REQ-010 The period counter cnt SHALL run 0..P-1 and wrap to 0.
REQ-011 The internal step signal SHALL be high while cnt < max(P>>DUTY_SHIFT, 1).
REQ-012 P SHALL be max(active period, MIN_PERIOD).
REQ-013 The active period SHALL be updated only at the wrap (cnt==P-1); pulses are never truncated or stretched mid-period.
REQ-014 Period source by state:
- MOVE and MOVE_N: NUM_PERIOD.
- AUTO: shadow register, loaded from n on any cycle with d_v=1 and adopted at the next wrap.
REQ-015 On leaving IDLE, cnt SHALL start at 0.
REQ-016 drv_pulse SHALL equal the registered (step XOR cr[5]); the first active level appears 2 cycles after the cycle in which cr[0] or cr[1] is first sampled high.
REQ-017 In IDLE, step SHALL be 0, so drv_pulse = cr[5] one cycle later.
REQ-018 drv_dir SHALL latch cr[4] on the IDLE exit; cr[4] changes while busy SHALL be ignored.
REQ-019 stop (MOVE, MOVE_N, AUTO) and auto deassertion (AUTO) SHALL take effect at the next wrap: go to IDLE and pulse done.
REQ-020 MOVE_N entry SHALL load pulses_left=n_pulses.
REQ-021 In MOVE_N, pulses_left SHALL decrement on each cnt==0 cycle that emits a pulse.
REQ-022 In MOVE_N, at the wrap with pulses_left==0, the FSM SHALL go to IDLE and pulse done.
REQ-023 start_N with n_pulses==0 SHALL stay in IDLE, assert done for one cycle and emit no pulse.
REQ-024 If drv_en_SM is low when cnt would restart at 0, cnt SHALL hold at 0 with step=0 and no decrement.
REQ-025 While the pause of REQ-024 persists, the FSM SHALL stay in its current state, but stop is still honoured immediately.
REQ-026 If drv_en_SM is low when start is sampled, the FSM SHALL enter the pause condition of REQ-024 directly.
REQ-027 All counter arithmetic SHALL be unsigned SIZE-bit; no value may exceed SIZE bits and pulses_left SHALL not underflow.
REQ-028 stop and a start edge in the same cycle SHALL resolve to stop (no start).
REQ-029 A d_v that coincides with the wrap SHALL have its new n adopted at the following wrap.

Reset
REQ-030 On rst low, all state SHALL clear asynchronously: regime=IDLE, cnt=0, step=0, drv_pulse=0, drv_dir=0, busy=0, done=0, pulses_left=0.
REQ-031 The shadow period SHALL reset to NUM_PERIOD and the edge-detect registers to 0.
REQ-032 Reset release SHALL be synchronised to clk.
REQ-033 A start level already high at reset release SHALL NOT trigger motion.

Structure
REQ-034 Package step_pulse_pkg SHALL hold:
- the regime state encoding;
- cr bit-index constants;
- MIN_PERIOD and DUTY_SHIFT defaults.
REQ-035 Sub-module step_period_timer SHALL contain the cnt, clamp, duty compare and wrap flag.
REQ-036 The FSM, pulse counting and output registers SHALL stay in the top level.

Verification
REQ-037 MOVE: start rise, drv_en_SM=1 -> drv_pulse period 2000 cycles, high 500; stop -> current pulse completes, then IDLE and a done strobe.
REQ-038 MOVE_N: n_pulses=3 -> exactly 3 pulses, pulses_left 3→0, done at the end of the third period; n_pulses=0 -> done with no pulse.
REQ-039 AUTO with d_v updates:
- n=100, then n=40 mid-period -> periods of 100 then 40, with the change only at the wrap;
- n=2 -> period clamped to 4, high 1.
REQ-040 Invert: cr[5]=1 in IDLE -> drv_pulse=1; in MOVE -> pulses active-low with identical timing.
REQ-041 Pause and reset:
- drv_en_SM low mid-pulse -> current pulse completes, then output held inactive; re-enable -> resumes at cnt=0.
- rst low mid-MOVE_N -> all outputs immediately at reset values.
